// File: rtl/lru_arb_pkg.sv
// Shared types and defaults for the LRU arbiter requester agent.
package lru_arb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_e;

    // Burst length field encodes beats minus one.
    function automatic int unsigned beats_from_len(input int unsigned len);
        return len + 1;
    endfunction

    localparam int unsigned MAX_BEATS_DEF = beats_from_len((1 << LEN_W_DEF) - 1);

endpackage

// File: rtl/lru_arb_req_fifo.sv
// Command FIFO for the requester: DEPTH entries of WIDTH bits with occupancy count.
module lru_arb_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full refuses pushes, even when a pop happens in the same cycle.
    assign ready   = (count != CW'(DEPTH));
    assign do_push = push & ready;
    assign do_pop  = pop & (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lru_arb_requester.sv
// Requester agent: queues bursts, requests the arbiter, holds busy and forwards
// beats onto the shared bus while it owns the resource.
module lru_arb_requester
    import lru_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_W-1:0]       cmd_len,
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic                   req,
    input  logic                   gnt,
    output logic                   busy,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [DATA_W-1:0]      src_data,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic [DATA_W-1:0]      bus_data,
    output logic                   bus_last
);

    state_e           state;
    state_e           state_nxt;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] head_len;
    logic             pop;
    logic             beat_done;

    lru_arb_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LEN_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .wr_data (cmd_len),
        .pop     (pop),
        .rd_data (head_len),
        .count   (cmd_count),
        .ready   (cmd_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the bus pass-through, which is only open in XFER.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        beat_done = 1'b0;
        bus_valid = 1'b0;
        bus_last  = 1'b0;
        bus_data  = '0;
        src_ready = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_count != '0) state_nxt = REQ;
            end
            REQ: begin
                if (gnt) begin
                    pop       = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                bus_valid = src_valid;
                src_ready = bus_ready;
                bus_data  = src_data;
                bus_last  = (beat_cnt == '0);
                beat_done = src_valid & bus_ready;
                if (beat_done && bus_last) state_nxt = REL;
            end
            REL: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // req/busy registered from the next state; beat counter loads on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req      <= 1'b0;
            busy     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            req  <= (state_nxt == REQ);
            busy <= (state_nxt == XFER);
            if (pop)
                beat_cnt <= head_len;
            else if (beat_done && !bus_last)
                beat_cnt <= beat_cnt - LEN_W'(1);
        end
    end

endmodule

// File: doc/lru_arb_requester.md
Name: lru_arb_requester

Overview:
- Requester-side agent for the LRU arbiter. It queues burst commands, raises one request line toward the arbiter and waits for the grant.
- While it owns the resource it holds busy (feeds the arbiter's gnt_busy bit) and forwards the burst's data beats onto the shared bus.
- It releases ownership after the last beat.
- One instance sits on each arbiter input port.

Parameters:
- DATA_W, 32, width of a data beat.
- LEN_W, 4, width of the burst-length field; beats per burst = cmd_len+1 (1..2^LEN_W).
- DEPTH, 4, command FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept a command (not full).
- cmd_len  input  LEN_W  burst length minus one.
- cmd_count  output  $clog2(DEPTH)+1  commands currently queued.
- req  output  1  request to the arbiter.
- gnt  input  1  grant from the arbiter.
- busy  output  1  ownership held; drives this port's gnt_busy bit.
- src_valid  input  1  upstream data beat valid.
- src_ready  output  1  upstream beat accepted.
- src_data  input  DATA_W  upstream data.
- bus_valid  output  1  bus beat valid.
- bus_ready  input  1  bus accepts beat.
- bus_data  output  DATA_W  bus data.
- bus_last  output  1  final beat of the burst.

Behaviour:
- Reset (async assert, release on the clock edge):
  - state=IDLE; FIFO emptied; cmd_count=0.
  - req=0, busy=0, bus_valid=0, bus_last=0, src_ready=0; cmd_ready=1.
  - bus_data is don't-care but driven 0.
- Command FIFO:
  - Push on cmd_valid&cmd_ready.
  - cmd_ready = (cmd_count != DEPTH), computed combinationally from the registered count.
  - A push while full is dropped; cmd_ready is already low, so no overflow is possible.
  - Simultaneous push and pop: count unchanged; when full, the push is still refused in that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, REQ, XFER, REL.
  - IDLE: req=0, busy=0. If cmd_count!=0, go to REQ next cycle. The earliest req is the cycle after the first push.
  - REQ: req=1 (registered). On gnt=1, go to XFER:
    - pop the FIFO head;
    - load beat counter = cmd_len;
    - assert busy=1 from the next cycle, with req=0 in that same cycle.
  - gnt is ignored outside REQ.
  - XFER: busy=1, bus_valid=src_valid, src_ready=bus_ready, bus_data=src_data (combinational pass-through).
    - A beat completes on src_valid&bus_ready.
    - bus_last=1 when beat counter==0.
    - Counter decrements on each completed non-last beat.
    - On the completed last beat, go to REL.
    - Deassertion of gnt during XFER is ignored; ownership is held through busy.
  - REL: busy=0, req=0 for exactly one cycle so the arbiter updates LRU status. Then IDLE.
  - IDLE→REQ is evaluated normally after REL, so the minimum req-to-req gap is 2 cycles (REL, IDLE).
- Throughput and latency:
  - Grant-to-first-beat latency is 1 cycle.
  - A burst of N beats with data always ready occupies N cycles of busy.
- Bus outputs outside XFER: bus_valid=0, bus_last=0, src_ready=0.
- Reset mid-burst:
  - Outputs drop immediately; the current burst is abandoned.
  - Queued commands are discarded.
  - No bus_last is generated.

Decomposition:
- Shared package lru_arb_pkg:
  - state enum {IDLE, REQ, XFER, REL};
  - LEN_W/DATA_W defaults;
  - beats-from-length helper constant/function.
- One sub-module, lru_arb_req_fifo: parameterised DEPTH×LEN_W synchronous FIFO with count output, same clk/rst.
- The FSM, beat counter and datapath mux stay in the top module.

Test Plan:
- Reset released, no commands → req=0, busy=0, cmd_ready=1, cmd_count=0 for 10 cycles.
- Push cmd_len=3, gnt held 1, src_valid and bus_ready held 1 → timing:
  - req rises the cycle after the push;
  - busy high exactly 4 cycles starting 1 cycle after gnt;
  - bus_last only on the 4th beat;
  - one REL cycle with busy=0.
- Push 4 commands back-to-back (DEPTH=4) with gnt=0, then a 5th push → cmd_count=4, cmd_ready=0, 5th dropped. After one grant, cmd_count=3 and cmd_ready=1.
- During XFER of cmd_len=2, toggle bus_ready 1,0,1,0,1 and drop gnt after the first beat → exactly 3 beats transferred, busy held throughout, bus_last on the 3rd accepted beat.
- Assert rst on the 2nd beat of a 4-beat burst with 2 commands queued → busy, req and bus_valid go 0 asynchronously; after release cmd_count=0 and state=IDLE.
- cmd_len=0 and cmd_len=15 bursts → 1 beat with bus_last on the first beat; 16 beats with the counter wrapping to 0 only on the last beat.
